// File: rtl/dlx_imem_if.sv
// rtl/dlx_imem_if.sv - fetch and loader bundle between DLX core and instruction memory
//
// Signals:
//   IAddr   core -> mem  32    byte address of the fetch
//   IRead   core -> mem  1     fetch request strobe
//   IIn     mem -> core  32    fetched instruction, registered
//   IValid  mem -> core  1     IIn carries the response to the previous edge's IRead
//   LdEn    core -> mem  1     loader write strobe
//   LdAddr  core -> mem  AW    loader word index
//   LdData  core -> mem  32    loader write data
//   LdReady mem -> core  1     memory is running and accepts fetches and loads
//   LdCount mem -> core  AW+1  accepted loader writes since reset, saturating at 2**AW
//   IFault  mem -> core  1     misaligned or out-of-range fetch (DLX_IMEM_ALIGN_CHK_EN only)
interface dlx_imem_if #(
  parameter int AW = 6
);
  logic [31:0] IAddr;
  logic        IRead;
  logic [31:0] IIn;
  logic        IValid;
  logic        LdEn;
  logic [AW-1:0] LdAddr;
  logic [31:0] LdData;
  logic        LdReady;
  logic [AW:0] LdCount;
`ifdef DLX_IMEM_ALIGN_CHK_EN
  logic        IFault;
`endif

  modport master (
    output IAddr, IRead, LdEn, LdAddr, LdData,
`ifdef DLX_IMEM_ALIGN_CHK_EN
    input  IFault,
`endif
    input  IIn, IValid, LdReady, LdCount
  );

  modport slave (
    input  IAddr, IRead, LdEn, LdAddr, LdData,
`ifdef DLX_IMEM_ALIGN_CHK_EN
    output IFault,
`endif
    output IIn, IValid, LdReady, LdCount
  );
endinterface

// File: rtl/dlx_imem.sv
// rtl/dlx_imem.sv - DLX instruction memory with NOP clear sweep, loader port and 1-cycle fetch
//
// Purpose: answers core fetches from an internal DEPTH x 32 word array. After
// reset the array is swept to NOP_WORD (CLEAR, DEPTH cycles), then RUN serves
// fetches and loader writes. Fetches past the array return NOP_WORD.
// Optional feature macro: DLX_IMEM_ALIGN_CHK_EN (adds IFault; misaligned
// fetches return NOP_WORD and fault, out-of-range fetches fault too).
//
// Ports:
//   PHI1  in  clock, all state changes on posedge
//   MRST  in  synchronous active-high reset
//   bus   dlx_imem_if.slave: IAddr/IRead/IIn/IValid fetch side,
//         LdEn/LdAddr/LdData/LdReady/LdCount loader side, IFault when enabled
module dlx_imem #(
  parameter int          DEPTH    = 64,
  parameter int          AW       = 6,
  parameter logic [31:0] NOP_WORD = {6'b000000, 20'b0, 6'b000000}
) (
  input  logic       PHI1,
  input  logic       MRST,
  dlx_imem_if.slave  bus
);

  localparam logic [0:0]  ST_CLEAR = 1'b0;
  localparam logic [0:0]  ST_RUN   = 1'b1;
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [31:0]   mem_q [DEPTH];

  logic [0:0]    state_q, state_d;
  // One bit wider than an index so the sweep reaches DEPTH-1 without wrapping.
  logic [AW:0]   clr_cnt_q, clr_cnt_d;
  logic [AW:0]   ld_cnt_q, ld_cnt_d;
  logic [31:0]   iin_q, iin_d;
  logic          ivalid_q, ivalid_d;

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [31:0]   wr_data;

  logic [AW-1:0] rd_idx;
  logic          out_of_range;
  logic [31:0]   rd_word;

  assign rd_idx       = bus.IAddr[AW+1:2];
  assign out_of_range = |bus.IAddr[31:AW+2];

`ifdef DLX_IMEM_ALIGN_CHK_EN
  logic ifault_q, ifault_d;
  logic misaligned;
  assign misaligned = |bus.IAddr[1:0];
  assign bus.IFault = ifault_q;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^bus.IAddr[1:0];
`endif

  // Write-first: a load to the word being fetched in the same cycle is
  // forwarded so the core sees the new instruction immediately.
  always_comb begin
    rd_word = mem_q[rd_idx];
    if (bus.LdEn && (bus.LdAddr == rd_idx)) begin
      rd_word = bus.LdData;
    end
    if (out_of_range) begin
      rd_word = NOP_WORD;
    end
`ifdef DLX_IMEM_ALIGN_CHK_EN
    if (misaligned) begin
      rd_word = NOP_WORD;
    end
`endif
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ld_cnt_d  = ld_cnt_q;
    iin_d     = iin_q;
    ivalid_d  = 1'b0;
    wr_en     = 1'b0;
    wr_idx    = bus.LdAddr;
    wr_data   = bus.LdData;
`ifdef DLX_IMEM_ALIGN_CHK_EN
    ifault_d  = 1'b0;
`endif
    case (state_q)
      ST_CLEAR: begin
        // Loader and fetch inputs are ignored while the sweep owns the array.
        wr_en     = !MRST;
        wr_idx    = clr_cnt_q[AW-1:0];
        wr_data   = NOP_WORD;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.LdEn) begin
          wr_en = !MRST;
          if (ld_cnt_q != FULL_CNT) begin
            ld_cnt_d = ld_cnt_q + 1'b1;
          end
        end
        if (bus.IRead) begin
          iin_d    = rd_word;
          ivalid_d = 1'b1;
`ifdef DLX_IMEM_ALIGN_CHK_EN
          ifault_d = out_of_range | misaligned;
`endif
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge PHI1) begin
    if (MRST) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      ld_cnt_q  <= '0;
      iin_q     <= NOP_WORD;
      ivalid_q  <= 1'b0;
`ifdef DLX_IMEM_ALIGN_CHK_EN
      ifault_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
      iin_q     <= iin_d;
      ivalid_q  <= ivalid_d;
`ifdef DLX_IMEM_ALIGN_CHK_EN
      ifault_q  <= ifault_d;
`endif
    end
  end

  always_ff @(posedge PHI1) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign bus.IIn     = iin_q;
  assign bus.IValid  = ivalid_q;
  assign bus.LdReady = (state_q == ST_RUN);
  assign bus.LdCount = ld_cnt_q;

endmodule

// File: tb/tb_dlx_imem.sv
// tb/tb_dlx_imem.sv - scoreboard bench for dlx_imem with randomized fetch/load traffic
module tb_dlx_imem;
  localparam int          DEPTH = 64;
  localparam int          AW    = 6;
  localparam logic [31:0] NOP   = {6'b000000, 20'b0, 6'b010101};

  logic clk = 1'b0;
  logic mrst = 1'b0;
  always #5 clk = ~clk;

  dlx_imem_if #(.AW(AW)) bus ();

  dlx_imem #(.DEPTH(DEPTH), .AW(AW), .NOP_WORD(NOP)) dut (
    .PHI1 (clk),
    .MRST (mrst),
    .bus  (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] word;
    bit          fault;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          started = 0;

  // Reference model: the array as the core sees it, plus simple counters.
  logic [31:0] m_mem [DEPTH];
  int          m_clr = 0;
  bit          m_ready = 0;
  int          m_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model_fetch(input logic [31:0] a);
    exp_t e;
    e.due   = cyc + 1;
    e.fault = 0;
    if (a >= DEPTH * 4) begin
      e.word  = NOP;
      e.fault = 1;
    end else begin
      e.word = m_mem[a / 4];
`ifdef DLX_IMEM_ALIGN_CHK_EN
      if (a % 4 != 0) begin
        e.word  = NOP;
        e.fault = 1;
      end
`endif
    end
    return e;
  endfunction

  // Drive one cycle, advance the model across the edge, return 1 time unit after it.
  task automatic step(input bit rst, input bit rd, input logic [31:0] a,
                      input bit ld, input logic [AW-1:0] la, input logic [31:0] ld_d);
    int  n_clr;
    bit  n_ready;
    int  n_cnt;
    mrst         = rst;
    bus.IRead    = rd;
    bus.IAddr    = a;
    bus.LdEn     = ld;
    bus.LdAddr   = la;
    bus.LdData   = ld_d;
    n_clr   = m_clr;
    n_ready = m_ready;
    n_cnt   = m_cnt;
    if (rst) begin
      n_clr   = 0;
      n_ready = 0;
      n_cnt   = 0;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
    end else if (!m_ready) begin
      n_clr = m_clr + 1;
      if (n_clr == DEPTH) n_ready = 1;
    end else begin
      if (ld) begin
        m_mem[la] = ld_d;
        n_cnt = (m_cnt + 1 > DEPTH) ? DEPTH : m_cnt + 1;
      end
      if (rd) sb.push_back(model_fetch(a));
    end
    @(posedge clk);
    #1;
    m_clr   = n_clr;
    m_ready = n_ready;
    m_cnt   = n_cnt;
  endtask

  task automatic idle();
    step(0, 0, 32'h0, 0, '0, 32'h0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.LdReady && n < 200) begin
      idle();
      n++;
    end
  endtask

  // Monitor: every response due this cycle must be present, none otherwise.
  always @(negedge clk) begin
    if (started) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        exp_t stale;
        stale = sb.pop_front();
        check("stale_response", 32'(stale.due), 32'(cyc));
      end
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("ivalid_resp", 32'(bus.IValid), 32'h1);
        check("iin_resp", bus.IIn, e.word);
`ifdef DLX_IMEM_ALIGN_CHK_EN
        check("ifault_resp", 32'(bus.IFault), 32'(e.fault));
`endif
      end else begin
        check("ivalid_idle", 32'(bus.IValid), 32'h0);
      end
      check("ldready", 32'(bus.LdReady), 32'(m_ready));
      check("ldcount", 32'(bus.LdCount), 32'(m_cnt));
    end
  end

  logic [31:0] prog [4];

  initial begin
    int n;
    prog[0] = 32'h20210001;
    prog[1] = 32'h00211020;
    prog[2] = 32'h00421821;
    prog[3] = 32'h08000010;

    bus.IRead = 0; bus.IAddr = 0; bus.LdEn = 0; bus.LdAddr = 0; bus.LdData = 0;

    // Reset and clear sweep.
    step(1, 0, 32'h0, 0, '0, 32'h0);
    started = 1;
    check("rst_iin", bus.IIn, NOP);
    check("rst_ivalid", 32'(bus.IValid), 32'h0);
    // Inputs during CLEAR must be ignored: loads are not counted, no response.
    step(0, 1, 32'h0, 1, 6'd2, 32'h12345678);
    wait_ready(n);
    check("clear_cycles", 32'(n + 1), 32'd64);

    // Cleared word reads as NOP.
    step(0, 1, 32'h10, 0, '0, 32'h0);
    idle();

    // Load program, then fetch back-to-back.
    for (int i = 0; i < 4; i++) step(0, 0, 32'h0, 1, 6'(i), prog[i]);
    for (int i = 0; i < 4; i++) step(0, 1, 32'(i * 4), 0, '0, 32'h0);
    idle();
    check("ldcount_prog", 32'(bus.LdCount), 32'd4);

    // Out of range.
    step(0, 1, 32'h100, 0, '0, 32'h0);
    step(0, 1, 32'hFFFFFFFC, 0, '0, 32'h0);
    idle();

    // Collision: write-first.
    step(0, 1, 32'h14, 1, 6'd5, 32'hDEADBEEF);
    check("collision_iin", bus.IIn, 32'hDEADBEEF);
    idle();

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
      step(0, 1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
           6'($urandom_range(0, 63)), $urandom);
    end
    idle();

    // Mid-operation reset during a fetch burst and a load.
    step(0, 1, 32'h0, 1, 6'd0, 32'hCAFEF00D);
    step(1, 1, 32'h4, 1, 6'd1, 32'h11111111);
    check("midrst_ivalid", 32'(bus.IValid), 32'h0);
    check("midrst_iin", bus.IIn, NOP);
    check("midrst_ldcount", 32'(bus.LdCount), 32'h0);
    check("midrst_ldready", 32'(bus.LdReady), 32'h0);
    wait_ready(n);
    check("clear_cycles_2", 32'(n), 32'd64);
    step(0, 1, 32'h0, 0, '0, 32'h0);
    check("post_clear_word0", bus.IIn, NOP);

    // Saturation and misalignment.
    for (int i = 0; i < 70; i++) step(0, 0, 32'h0, 1, 6'(i % 64), 32'hA5000000 + 32'(i));
    idle();
    check("ldcount_sat", 32'(bus.LdCount), 32'd64);
    step(0, 1, 32'h6, 0, '0, 32'h0);
`ifdef DLX_IMEM_ALIGN_CHK_EN
    check("misalign_iin", bus.IIn, NOP);
`else
    check("misalign_iin", bus.IIn, 32'hA5000041);
`endif
    idle();
    idle();
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule

// File: doc/dlx_imem.md
Name: dlx_imem

Overview:
- Instruction-memory responder for the DLX instruction-fetch interface: the other end of IAddr/IRead/IIn.
- Holds the program in an internal word array and returns the instruction for each fetch one cycle after the request.
- Word array is preloaded through a simple write port; the CPU core is the only fetch client.
- Out-of-range fetches return NOP, which replaces the bench-side memory model with synthesizable RTL.

Parameters:
- DEPTH, 64, number of 32-bit instruction words; must be a power of 2.
- AW, 6, word-address width; equals log2(DEPTH).
- NOP_WORD, {`SPECIAL, 20'b0, `NOP} from dlx.defines, word returned for empty, out-of-range or cleared locations.

Ports:
- PHI1 in 1: clock; all state updates on posedge.
- MRST in 1: reset, synchronous, active-high.
- IAddr in 32: byte address from core; word index = IAddr[AW+1:2].
- IRead in 1: fetch request strobe, sampled on posedge.
- IIn out 32: fetched instruction, registered.
- IValid out 1: one-cycle pulse; IIn holds the response for the IRead sampled on the previous edge.
- LdEn in 1: loader write strobe.
- LdAddr in AW: loader word index.
- LdData in 32: loader write data.
- LdReady out 1: memory is in RUN and accepts loader writes and fetches.
- LdCount out AW+1: number of accepted loader writes since reset; saturates at DEPTH.

Behaviour:
- States: CLEAR, RUN. Encoding is free.
- MRST=1 at an edge:
  - state<=CLEAR, clear counter<=0.
  - IIn<=NOP_WORD, IValid<=0, LdReady<=0, LdCount<=0.
  - Applies from any state, including mid-load or mid-fetch; any pending response is dropped.
- CLEAR:
  - Each cycle writes NOP_WORD to mem[counter], then increments counter.
  - After the write of index DEPTH-1: state<=RUN and LdReady<=1 on the same edge.
  - CLEAR therefore lasts exactly DEPTH cycles after MRST deasserts.
  - IRead and LdEn are ignored. IValid stays 0, IIn stays NOP_WORD.
- RUN, fetch:
  - IRead=1 at edge k: IIn<=word, IValid<=1 at edge k. Visible during cycle k..k+1; latency is 1 cycle.
  - IRead=0: IValid<=0; IIn holds its last value.
  - Back-to-back IRead every cycle: one response per cycle, no bubbles.
- RUN, word selection:
  - IAddr >= DEPTH*4 (any bit above AW+1 set): word = NOP_WORD.
  - Otherwise word = mem[IAddr[AW+1:2]].
  - IAddr[1:0] is ignored.
- RUN, load:
  - LdEn=1 at an edge: mem[LdAddr]<=LdData.
  - LdCount increments, saturating at DEPTH (it does not wrap).
- Simultaneous load and fetch:
  - Same word: write-first; IIn returns LdData.
  - Different words: both complete in the same cycle.
- LdEn during CLEAR is dropped and not counted.
- Clear counter is AW+1 bits wide, so the last index does not wrap to 0 early.
- No X on IIn after reset. Memory contents are undefined only before the first reset.

Optional Feature:
- Macro: DLX_IMEM_ALIGN_CHK_EN.
- Defined:
  - Adds output IFault (1 bit, reset 0).
  - A fetch with IAddr[1:0]!=0 returns NOP_WORD and pulses IFault with IValid.
  - An out-of-range fetch also pulses IFault.
- Not defined:
  - IFault port is absent.
  - Low bits are ignored and out-of-range fetches return NOP_WORD silently.

Test Plan:
- Reset/clear: MRST=1 for 1 cycle, then 0 → LdReady=0 for exactly 64 cycles, then 1. A subsequent fetch of IAddr=0x10 returns NOP_WORD with IValid=1 one cycle after IRead.
- Load and fetch: load words 0..3 = 0x20210001, 0x00211020, 0x00421821, 0x08000010. Fetch IAddr=0,4,8,12 on consecutive cycles → IIn matches in order, IValid held 1 for 4 cycles. LdCount=4.
- Out of range: fetch IAddr=0x100 and IAddr=0xFFFFFFFC → IIn=NOP_WORD. With DLX_IMEM_ALIGN_CHK_EN, IFault=1 on both responses.
- Collision: in the same cycle LdEn=1, LdAddr=5, LdData=0xDEADBEEF and IRead=1, IAddr=0x14 → next cycle IIn=0xDEADBEEF.
- Mid-operation reset: assert MRST during a fetch burst and a load → next edge IValid=0, IIn=NOP_WORD, LdCount=0, LdReady=0. Earlier loads are overwritten with NOP after CLEAR; a fetch of word 0 returns NOP_WORD.
- Saturation and misalignment: 70 loads → LdCount=64. Fetch IAddr=0x6 → returns mem[1] without the macro; with the macro it returns NOP_WORD and IFault=1.
